// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint - core-local interruptor for a single-hart core.
//
// Holds the machine software-interrupt bit, the 64-bit mtime counter (advanced
// by a divided real-time tick) and the 64-bit mtimecmp compare register, all
// reachable through a simple valid/ready memory-mapped slave port. Every
// request is answered exactly one cycle after it is presented.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous reset, active-low
//   mem_valid  request strobe (one cycle per request)
//   mem_instr  instruction-fetch flag, not used for decode
//   mem_addr   byte address, bits [15:2] select the word
//   mem_wdata  write data
//   mem_wstrb  byte enables, 0 = read, non-zero = write
//   mem_rdata  read data, 0 whenever mem_ready is low
//   mem_ready  response strobe, high for exactly one cycle
//   msip       machine software-interrupt pending
//   mtip       machine timer-interrupt pending (registered compare)
//   mtime      current mtime value
// -----------------------------------------------------------------------------
module clint #(
   parameter int unsigned rtc_div = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        msip,
   output logic        mtip,
   output logic [63:0] mtime
);

   // A one-bit counter is kept even for rtc_div = 1; it simply sits at 0.
   localparam int unsigned CW = (rtc_div > 1) ? $clog2(rtc_div) : 1;
   localparam logic [CW-1:0] PRESC_LAST = CW'(rtc_div - 1);

   // Word offsets (mem_addr[15:2]).
   localparam logic [13:0] OFF_MSIP   = 14'h0000;
   localparam logic [13:0] OFF_CMP_LO = 14'h1000;
   localparam logic [13:0] OFF_CMP_HI = 14'h1001;
   localparam logic [13:0] OFF_TIM_LO = 14'h2FFE;
   localparam logic [13:0] OFF_TIM_HI = 14'h2FFF;

   logic [CW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic          mtip_q, mtip_d;
   logic          ready_q, ready_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [13:0]   word;
   logic          wr;
   logic          tick;
   logic [63:0]   mtime_inc;
   logic [31:0]   rd_mux;

   // Bits that are deliberately not decoded.
   logic unused_bits;
   assign unused_bits = ^{mem_instr, mem_addr[31:16], mem_addr[1:0]};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      end
      return res;
   endfunction

   always_comb begin
      word      = mem_addr[15:2];
      wr        = mem_valid && (mem_wstrb != 4'h0);
      tick      = (presc_q == PRESC_LAST);
      presc_d   = tick ? '0 : presc_q + 1'b1;

      // The increment is formed on the full 64 bits, so the low-to-high carry
      // is applied even when the other word is being overwritten this cycle.
      mtime_inc  = mtime_q + 64'd1;
      mtime_d    = tick ? mtime_inc : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;

      if (wr) begin
         case (word)
            OFF_MSIP:   if (mem_wstrb[0]) msip_d = mem_wdata[0];
            OFF_CMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  mem_wdata, mem_wstrb);
            OFF_CMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
            OFF_TIM_LO: mtime_d[31:0]     = merge_bytes(mtime_d[31:0],     mem_wdata, mem_wstrb);
            OFF_TIM_HI: mtime_d[63:32]    = merge_bytes(mtime_d[63:32],    mem_wdata, mem_wstrb);
            default:    ;
         endcase
      end

      // Read data reflects register contents before this edge's update.
      case (word)
         OFF_MSIP:   rd_mux = {31'b0, msip_q};
         OFF_CMP_LO: rd_mux = mtimecmp_q[31:0];
         OFF_CMP_HI: rd_mux = mtimecmp_q[63:32];
         OFF_TIM_LO: rd_mux = mtime_q[31:0];
         OFF_TIM_HI: rd_mux = mtime_q[63:32];
         default:    rd_mux = 32'h0;
      endcase

      ready_d = mem_valid;
      rdata_d = mem_valid ? rd_mux : 32'h0;
      mtip_d  = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q    <= '0;
         mtime_q    <= 64'h0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q     <= 1'b0;
         mtip_q     <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= 32'h0;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         mtip_q     <= mtip_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;
   assign msip      = msip_q;
   assign mtip      = mtip_q;
   assign mtime     = mtime_q;

endmodule

// File: doc/clint.md
# clint

Core-local interruptor for the single-hart core. It holds the machine software-interrupt bit, the 64-bit `mtime` counter driven by a divided real-time tick, and the 64-bit `mtimecmp` compare register, all behind a memory-mapped slave port. It sits directly upstream of the CSR unit and drives that unit's `msip`, `mtip` and `mtime` inputs.

## Interface
- `rtc_div`, default 10: clk cycles per `mtime` increment; must be ≥1.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `mem_valid`  in  1: request strobe, one cycle per request.
- `mem_instr`  in  1: instruction-fetch flag; ignored for decode, no side effect.
- `mem_addr`  in  32: byte address; only `mem_addr[15:2]` is decoded.
- `mem_wdata`  in  32: write data.
- `mem_wstrb`  in  4: byte enables; 0 = read, non-zero = write.
- `mem_rdata`  out  32: read data, valid when `mem_ready` = 1, else 0.
- `mem_ready`  out  1: response strobe.
- `msip`  out  1: machine software-interrupt pending.
- `mtip`  out  1: machine timer-interrupt pending.
- `mtime`  out  64: current `mtime` value.

## Operation
- Register map, offsets decoded from `mem_addr[15:0]`:
  - 0x0000 is `msip`, bit 0 only; bits 31:1 read 0.
  - 0x4000 is `mtimecmp[31:0]`.
  - 0x4004 is `mtimecmp[63:32]`.
  - 0xBFF8 is `mtime[31:0]`.
  - 0xBFFC is `mtime[63:32]`.
- Any other offset reads 0. Writes to it are dropped, but it still gets a response.
- Writes are byte-masked: byte k of the target word is updated only when `mem_wstrb[k]` = 1. For `msip`, only `wstrb[0]` matters.
- Prescaler: a counter of width clog2(`rtc_div`) counts 0..`rtc_div`-1 and wraps.
  - A tick is generated in the cycle the counter equals `rtc_div`-1.
  - When `rtc_div` = 1, every cycle is a tick.
- `mtime` increments by 1 on each tick, modulo 2^64. The carry from the low to the high word is handled in the same cycle.
- A bus write to either `mtime` word in the same cycle as a tick takes priority: the written bytes take the written value; the other word still increments normally, including any carry.
- The prescaler is not reset by `mtime` writes.
- `mtip` is a register loaded every cycle with (`mtime` ≥ `mtimecmp`), unsigned 64-bit compare on the current register values.
- `msip` output equals the `msip` register bit.
- Reset values:
  - `mtime` = 0, prescaler = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `msip` = 0, `mtip` = 0.
  - `mem_ready` = 0, `mem_rdata` = 0.
- Reset asserted mid-transaction drops the pending response: `mem_ready` = 0 immediately, with no write side effect if the write edge has not yet occurred.

## Timing
- Every request gets its response exactly 1 cycle later. `mem_ready` = 1 for exactly that cycle.
- Back-to-back requests, with `mem_valid` high on consecutive cycles, are all served, each 1 cycle later. There is no stall or backpressure.
- A write takes effect at the rising edge that samples `mem_valid`. A read in the next cycle returns the new value.
- Read data is the register value at the sampling edge, before that edge's update. A read of `mtime` during a tick returns the pre-increment value.
- Latency from register change to outputs:
  - `mtime` output follows the register with zero latency.
  - `mtip` lags by 1 cycle: a compare that becomes true after edge n shows `mtip` = 1 after edge n+1.
  - Same 1-cycle lag when the compare becomes false, e.g. after a `mtimecmp` write.
- `msip` changes at the write edge.
- Writing the `mtimecmp` halves is non-atomic. Intermediate values are compared and may briefly raise `mtip`; this is required behaviour.

## Test plan
- Reset then idle, `rtc_div` = 4, no bus traffic for 20 cycles:
  - `mtime` = 5 at cycle 20; `mtip` = 0, `msip` = 0.
  - Ticks fall at cycles 4, 8, 12, 16, 20, counting from reset release as cycle 1.
- Write 0x1 to 0x0000 with `wstrb` = 4'hF:
  - `msip` = 1 after the edge.
  - A read of 0x0000 returns 0x00000001 with `mem_ready` 1 cycle after `mem_valid`.
  - Writing 0x0 clears it.
- Set `mtimecmp` = 0x0000_0000_0000_0003 by writing the high word then the low word, with `rtc_div` = 1:
  - `mtip` rises exactly 1 cycle after `mtime` reaches 3.
  - Writing high word 0x1 drops `mtip` 1 cycle later.
- Write `mtime` low = 0xFFFF_FFFF, high = 0, with `rtc_div` = 1:
  - Next tick gives `mtime` = 0x0000_0001_0000_0000.
  - A write of low word 0x10 coinciding with a tick yields low = 0x10.
- Byte strobe: write 0xAABBCCDD to 0x4000 with `wstrb` = 4'b0101 over reset value all-ones:
  - A read returns 0xFFBBFFDD.
  - Unmapped read of 0x1234 returns 0 with `mem_ready` = 1.
- Assert `rst` = 0 in the cycle after a read request:
  - `mem_ready` = 0 and all registers return to reset values without waiting for a clock edge.
